// File: rtl/step_dir_driver_pkg.sv
// Shared definitions for the step/dir driver: command encoding, emitter
// state codes and default timing constants.
package step_dir_driver_pkg;

    // One buffered step: axis 0 = X, 1 = Y; sign 0 = positive, 1 = negative
    typedef struct packed {
        logic axis;
        logic sign;
    } step_cmd_t;

    localparam step_cmd_t CMD_XP = 2'b00;
    localparam step_cmd_t CMD_XN = 2'b01;
    localparam step_cmd_t CMD_YP = 2'b10;
    localparam step_cmd_t CMD_YN = 2'b11;

    // Emitter state codes
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_HIGH  = 2'd2;
    localparam logic [1:0] ST_LOW   = 2'd3;

    // Default timing / sizing
    localparam int DEF_FIFO_DEPTH = 16;
    localparam int DEF_DIR_SETUP  = 4;
    localparam int DEF_PULSE_HI   = 3;
    localparam int DEF_PULSE_LO   = 3;
    localparam int DEF_POS_W      = 24;

    // Largest of three phase lengths, used to size the shared phase counter
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/step_dir_driver_fifo.sv
// Step-command buffer: synchronous FIFO of step_cmd_t. Pointers carry one
// extra wrap bit so full and empty are distinguishable without a counter.
module step_cmd_fifo
    import step_dir_driver_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic      pulse_clk,
    input  logic      sys_rstH,
    input  logic      push,
    input  step_cmd_t push_data,
    input  logic      pop,
    output step_cmd_t head,
    output logic      full,
    output logic      empty
);
    localparam int AW = $clog2(FIFO_DEPTH);

    step_cmd_t   mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        wr_en;
    logic        rd_en;

    // A push into a full FIFO is accepted only if the head leaves the same cycle
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // Pointer update; reset discards everything queued
    always_ff @(posedge pulse_clk) begin
        if (sys_rstH) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because empty gates every read
    always_ff @(posedge pulse_clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/step_dir_driver.sv
// Step/dir driver: buffers interpolator step requests, turns each one into a
// timed DIR-setup / STEP-high / STEP-low sequence on one axis at a time,
// tracks signed axis positions and flags segment completion.
module step_dir_driver
    import step_dir_driver_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int DIR_SETUP  = DEF_DIR_SETUP,
    parameter int PULSE_HI   = DEF_PULSE_HI,
    parameter int PULSE_LO   = DEF_PULSE_LO,
    parameter int POS_W      = DEF_POS_W
) (
    input  logic                    pulse_clk,
    input  logic                    sys_rstH,
    input  logic                    X_acc,
    input  logic                    X_dec,
    input  logic                    Y_acc,
    input  logic                    Y_dec,
    input  logic                    draw_overH,
    output logic                    X_step,
    output logic                    X_dir,
    output logic                    Y_step,
    output logic                    Y_dir,
    output logic signed [POS_W-1:0] X_pos,
    output logic signed [POS_W-1:0] Y_pos,
    output logic                    seg_doneH,
    output logic                    busyH,
    output logic                    ovf_errH
);
    localparam int CNT_MAX = max3(DIR_SETUP, PULSE_HI, PULSE_LO);
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    step_cmd_t        cur_cmd;

    logic [2:0]       req_cnt;
    logic             push_req;
    logic             multi_req;
    step_cmd_t        cmd_in;
    step_cmd_t        head_cmd;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             tgt_dir;
    logic             dir_flip;
    logic             first_hi;
    logic             draw_q;
    logic             draw_pend;
    logic             seg_cond;

    // Capture decode: exactly one request pushes, several at once is an error
    always_comb begin
        req_cnt   = 3'(X_acc) + 3'(X_dec) + 3'(Y_acc) + 3'(Y_dec);
        push_req  = (req_cnt == 3'd1);
        multi_req = (req_cnt > 3'd1);
        if (X_acc)      cmd_in = CMD_XP;
        else if (X_dec) cmd_in = CMD_XN;
        else if (Y_acc) cmd_in = CMD_YP;
        else            cmd_in = CMD_YN;
    end

    step_cmd_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .pulse_clk (pulse_clk),
        .sys_rstH  (sys_rstH),
        .push      (push_req),
        .push_data (cmd_in),
        .pop       (fifo_pop),
        .head      (head_cmd),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Head-of-queue direction check: DIR 1 means positive travel
    always_comb begin
        fifo_pop = (state == ST_IDLE) && !fifo_empty;
        tgt_dir  = ~head_cmd.sign;
        dir_flip = head_cmd.axis ? (Y_dir != tgt_dir) : (X_dir != tgt_dir);
        first_hi = (state == ST_HIGH) && (cnt == CNT_W'(PULSE_HI - 1));
        seg_cond = draw_pend && fifo_empty && (state == ST_IDLE);
    end

    assign busyH = !fifo_empty || (state != ST_IDLE);

    // Sticky overflow: lost command from a full FIFO or an illegal combination
    always_ff @(posedge pulse_clk) begin
        if (sys_rstH)
            ovf_errH <= 1'b0;
        else if (multi_req || (push_req && fifo_full && !fifo_pop))
            ovf_errH <= 1'b1;
    end

    // Emitter FSM: pop, optional DIR setup wait, STEP high, STEP low
    always_ff @(posedge pulse_clk) begin
        if (sys_rstH) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            cur_cmd <= CMD_XP;
            X_step  <= 1'b0;
            Y_step  <= 1'b0;
            X_dir   <= 1'b0;
            Y_dir   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        cur_cmd <= head_cmd;
                        // Rewriting an unchanged DIR is harmless
                        if (head_cmd.axis) Y_dir <= tgt_dir;
                        else               X_dir <= tgt_dir;
                        if (dir_flip && (DIR_SETUP > 0)) begin
                            state <= ST_SETUP;
                            cnt   <= CNT_W'(DIR_SETUP - 1);
                        end else begin
                            state <= ST_HIGH;
                            cnt   <= CNT_W'(PULSE_HI - 1);
                            if (head_cmd.axis) Y_step <= 1'b1;
                            else               X_step <= 1'b1;
                        end
                    end
                end
                ST_SETUP: begin
                    if (cnt == '0) begin
                        state <= ST_HIGH;
                        cnt   <= CNT_W'(PULSE_HI - 1);
                        if (cur_cmd.axis) Y_step <= 1'b1;
                        else              X_step <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (cnt == '0) begin
                        state  <= ST_LOW;
                        cnt    <= CNT_W'(PULSE_LO - 1);
                        X_step <= 1'b0;
                        Y_step <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_LOW: begin
                    if (cnt == '0) state <= ST_IDLE;
                    else           cnt   <= cnt - 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Position counters: one count per pulse, taken on its first HIGH cycle; wrap freely
    always_ff @(posedge pulse_clk) begin
        if (sys_rstH) begin
            X_pos <= '0;
            Y_pos <= '0;
        end else if (first_hi) begin
            if (cur_cmd.axis)
                Y_pos <= cur_cmd.sign ? Y_pos - POS_W'(1) : Y_pos + POS_W'(1);
            else
                X_pos <= cur_cmd.sign ? X_pos - POS_W'(1) : X_pos + POS_W'(1);
        end
    end

    // Completion: remember a draw_overH edge until the queue and emitter drain
    always_ff @(posedge pulse_clk) begin
        if (sys_rstH) begin
            draw_q    <= 1'b0;
            draw_pend <= 1'b0;
            seg_doneH <= 1'b0;
        end else begin
            draw_q    <= draw_overH;
            seg_doneH <= seg_cond;
            if (seg_cond)
                draw_pend <= 1'b0;
            else if (draw_overH && !draw_q)
                draw_pend <= 1'b1;
        end
    end

endmodule
